block_shuffle_engine: RTL

BLOCK_SHUFFLE_ENGINE -- requirements
Module: block_shuffle_engine

---
 rtl/block_shuffle_engine_if.sv | 32 +++
 rtl/block_shuffle_engine.sv | 98 +++++++++
 2 files changed

// File: rtl/block_shuffle_engine_if.sv
// Request/result bus of the block shuffle engine.
// The requester uses the master modport; the engine uses the slave modport.
interface block_shuffle_engine_if #(
    parameter int NIBBLES = 4,
    parameter int ROUND_W = 4
);
    localparam int W  = 4 * NIBBLES;
    localparam int SW = $clog2(NIBBLES);

    // Both channels use strict valid/ready: a transfer happens on a rising
    // edge where valid && ready. The engine only asserts out_valid when the
    // result is final and holds out_data until the transfer takes place.
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    logic                in_dir;
    logic [SW-1:0]       in_shift;
    logic [ROUND_W-1:0]  in_rounds;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;

    modport master (
        output in_valid, in_data, in_dir, in_shift, in_rounds, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_dir, in_shift, in_rounds, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/block_shuffle_engine.sv
// Rotates a block of 4-bit nibbles left or right by a latched amount, once per
// cycle for a latched number of rounds, then holds the result until consumed.
module block_shuffle_engine #(
    parameter int NIBBLES = 4,
    parameter int ROUND_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    block_shuffle_engine_if.slave    bus,
    output logic                     busy,
    output logic [1:0]               dbg_state_o
);
    localparam int W  = 4 * NIBBLES;
    localparam int SW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ROUND_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]        data_q, data_d;
    logic                dir_q, dir_d;
    logic [SW-1:0]       shift_q, shift_d;
    logic [W-1:0]        rot_w;

    // One round of rotation. Nibble indices wrap naturally in SW bits because
    // NIBBLES is a power of two.
    for (genvar g = 0; g < NIBBLES; g++) begin : g_rot
        logic [SW-1:0] src_left;
        logic [SW-1:0] src_right;
        assign src_left  = SW'(g) - shift_q;
        assign src_right = SW'(g) + shift_q;
        assign rot_w[4*g +: 4] = dir_q ? data_q[4*src_right +: 4]
                                       : data_q[4*src_left  +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            dir_q   <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dir_d   = dir_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    dir_d   = bus.in_dir;
                    shift_d = bus.in_shift;
                    cnt_d   = bus.in_rounds;
                    state_d = (bus.in_rounds == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                data_d = rot_w;
                cnt_d  = cnt_q - ROUND_W'(1);
                // The counter reaches zero together with the last rotation.
                if (cnt_q == ROUND_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.out_data  = data_q;
        busy          = (state_q != S_IDLE);
        dbg_state_o   = state_q;
    end
endmodule
